cam_xform_stream: RTL and testbench

CAM_XFORM_STREAM -- requirements
Module: cam_xform_stream

---
 rtl/cam_xform_pkg.sv | 26 ++
 rtl/cam_xform_stream_dot3.sv | 55 +++++
 rtl/cam_xform_stream.sv | 173 +++++++++++++++++
 tb/tb_cam_xform_stream.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_xform_pkg.sv
// cam_xform_pkg: widths, fixed-point constants and vec3 helpers shared by
// the camera transform stream (near clip enabled by CAM_XFORM_NEAR_CLIP_EN).
package cam_xform_pkg;

  localparam int DEF_FRAC_BITS = 14;
  localparam int IDENTITY_ONE  = 1 << DEF_FRAC_BITS;

  typedef enum logic [1:0] {
    AX_X = 2'd0,
    AX_Y = 2'd1,
    AX_Z = 2'd2
  } axis_e;

  typedef logic signed [15:0] comp16_t;
  typedef comp16_t [2:0]      vec3_16_t;

  function automatic int d_width(input int c_w, input int v_w,
                                 input int frac);
    return c_w + 1 + v_w - frac + 2;
  endfunction

  function automatic int one_fx(input int frac);
    return 1 << frac;
  endfunction

endpackage

// File: rtl/cam_xform_stream_dot3.sv
// dot3_stage: S2 full-precision products, S3 floor-shift and three-way sum
// for one camera axis; each register stage has its own load enable.
module dot3_stage
  import cam_xform_pkg::*;
#(
  parameter int A_WIDTH   = 19,
  parameter int V_WIDTH   = 16,
  parameter int FRAC_BITS = 14,
  localparam int D_WIDTH  = d_width(A_WIDTH - 1, V_WIDTH, FRAC_BITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_s2,
  input  logic                      en_s3,
  input  logic [2:0][A_WIDTH-1:0]   a,
  input  logic [2:0][V_WIDTH-1:0]   b,
  output logic signed [D_WIDTH-1:0] sum
);

  localparam int PR_W = A_WIDTH + V_WIDTH;
  localparam int SH_W = PR_W - FRAC_BITS;

  logic [2:0][PR_W-1:0] prod;
  logic [2:0][PR_W-1:0] prod_d;
  logic [2:0][SH_W-1:0] sh;
  logic [D_WIDTH-1:0]   sum_d;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      prod_d[i] = $signed({{V_WIDTH{a[i][A_WIDTH-1]}}, a[i]})
                * $signed({{A_WIDTH{b[i][V_WIDTH-1]}}, b[i]});
    end
  end

  // dropping the low bits of a two's complement value is a floor shift
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sh[i] = prod[i][PR_W-1:FRAC_BITS];
    end
    sum_d = {{2{sh[0][SH_W-1]}}, sh[0]}
          + {{2{sh[1][SH_W-1]}}, sh[1]}
          + {{2{sh[2][SH_W-1]}}, sh[2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
      sum  <= '0;
    end else begin
      if (en_s2) prod <= prod_d;
      if (en_s3) sum  <= sum_d;
    end
  end

endmodule

// File: rtl/cam_xform_stream.sv
// cam_xform_stream: 4-stage world-to-camera vertex transform with stall.
// Define CAM_XFORM_NEAR_CLIP_EN to drive out_clip from the near plane test.
module cam_xform_stream
  import cam_xform_pkg::*;
#(
  parameter int        C_WIDTH   = 18,
  parameter int        P_WIDTH   = 16,
  parameter int        V_WIDTH   = 16,
  parameter int        FRAC_BITS = 14,
  parameter int        TAG_WIDTH = 8,
  parameter int signed NEAR_Z    = 0,
  localparam int       D_WIDTH   = d_width(C_WIDTH, V_WIDTH, FRAC_BITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cam_wr,
  input  logic [2:0][C_WIDTH-1:0]   cam_c,
  input  logic [2:0][V_WIDTH-1:0]   cam_u,
  input  logic [2:0][V_WIDTH-1:0]   cam_v,
  input  logic [2:0][V_WIDTH-1:0]   cam_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0][P_WIDTH-1:0]   in_p,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [D_WIDTH-1:0] out_x,
  output logic signed [D_WIDTH-1:0] out_y,
  output logic signed [D_WIDTH-1:0] out_z,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      out_clip
);

  localparam int A_W = C_WIDTH + 1;
  localparam logic [V_WIDTH-1:0] ONE  = V_WIDTH'(one_fx(FRAC_BITS));
  localparam logic [V_WIDTH-1:0] ZERO = '0;
  localparam logic [2:0][V_WIDTH-1:0] ID_U = {ZERO, ZERO, ONE};
  localparam logic [2:0][V_WIDTH-1:0] ID_V = {ZERO, ONE, ZERO};
  localparam logic [2:0][V_WIDTH-1:0] ID_N = {ONE, ZERO, ZERO};

  logic [2:0][C_WIDTH-1:0] c_q;
  logic [2:0][V_WIDTH-1:0] u_q, v_q, n_q;

  logic ld1, ld2, ld3, ld4;
  logic vld1, vld2, vld3;

  logic [2:0][A_W-1:0]     pc_d, pc1;
  logic [2:0][V_WIDTH-1:0] u1, v1, n1;
  logic [TAG_WIDTH-1:0]    tag1, tag2, tag3;

  logic signed [D_WIDTH-1:0] x3, y3, z3;

  assign ld4 = ~out_valid | out_ready;
  assign ld3 = ~vld3 | ld4;
  assign ld2 = ~vld2 | ld3;
  assign ld1 = ~vld1 | ld2;
  assign in_ready = ~rst & ld1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
      u_q <= ID_U;
      v_q <= ID_V;
      n_q <= ID_N;
    end else if (cam_wr) begin
      c_q <= cam_c;
      u_q <= cam_u;
      v_q <= cam_v;
      n_q <= cam_n;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pc_d[i] = {{(A_W-P_WIDTH){in_p[i][P_WIDTH-1]}}, in_p[i]}
              - {c_q[i][C_WIDTH-1], c_q[i]};
    end
  end

  // S1 snapshots the basis so a later cam_wr cannot touch this vertex
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1 <= 1'b0;
      pc1  <= '0;
      u1   <= '0;
      v1   <= '0;
      n1   <= '0;
      tag1 <= '0;
    end else if (ld1) begin
      vld1 <= in_valid;
      if (in_valid) begin
        pc1  <= pc_d;
        u1   <= u_q;
        v1   <= v_q;
        n1   <= n_q;
        tag1 <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld2 <= 1'b0;
      vld3 <= 1'b0;
      tag2 <= '0;
      tag3 <= '0;
    end else begin
      if (ld2) begin
        vld2 <= vld1;
        tag2 <= tag1;
      end
      if (ld3) begin
        vld3 <= vld2;
        tag3 <= tag2;
      end
    end
  end

  dot3_stage #(
    .A_WIDTH(A_W), .V_WIDTH(V_WIDTH), .FRAC_BITS(FRAC_BITS)
  ) u_dot_u (
    .clk(clk), .rst(rst), .en_s2(ld2 & vld1), .en_s3(ld3 & vld2),
    .a(pc1), .b(u1), .sum(x3)
  );

  dot3_stage #(
    .A_WIDTH(A_W), .V_WIDTH(V_WIDTH), .FRAC_BITS(FRAC_BITS)
  ) u_dot_v (
    .clk(clk), .rst(rst), .en_s2(ld2 & vld1), .en_s3(ld3 & vld2),
    .a(pc1), .b(v1), .sum(y3)
  );

  dot3_stage #(
    .A_WIDTH(A_W), .V_WIDTH(V_WIDTH), .FRAC_BITS(FRAC_BITS)
  ) u_dot_n (
    .clk(clk), .rst(rst), .en_s2(ld2 & vld1), .en_s3(ld3 & vld2),
    .a(pc1), .b(n1), .sum(z3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      out_tag   <= '0;
    end else if (ld4) begin
      out_valid <= vld3;
      if (vld3) begin
        out_x   <= x3;
        out_y   <= y3;
        out_z   <= z3;
        out_tag <= tag3;
      end
    end
  end

`ifdef CAM_XFORM_NEAR_CLIP_EN
  logic clip3;
  assign clip3 = (z3 < NEAR_Z);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_clip <= 1'b0;
    end else if (ld4 && vld3) begin
      out_clip <= clip3;
    end
  end
`else
  assign out_clip = 1'b0;
`endif

endmodule

// File: tb/tb_cam_xform_stream.sv
// tb_cam_xform_stream: random and directed stimulus against a queue
// scoreboard fed by an arithmetic reference model of the transform.
module tb_cam_xform_stream;
  import cam_xform_pkg::*;

  localparam int CW = 18;
  localparam int PW = 16;
  localparam int VW = 16;
  localparam int FB = 14;
  localparam int TW = 8;
  localparam int NZ = 0;
  localparam int DW = d_width(CW, VW, FB);
  localparam int ONEV = 1 << FB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cam_wr = 1'b0;
  logic [2:0][CW-1:0] cam_c = '0;
  logic [2:0][VW-1:0] cam_u = '0;
  logic [2:0][VW-1:0] cam_v = '0;
  logic [2:0][VW-1:0] cam_n = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2:0][PW-1:0] in_p = '0;
  logic [TW-1:0] in_tag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [DW-1:0] out_x, out_y, out_z;
  logic [TW-1:0] out_tag;
  logic out_clip;

  cam_xform_stream #(
    .C_WIDTH(CW), .P_WIDTH(PW), .V_WIDTH(VW), .FRAC_BITS(FB),
    .TAG_WIDTH(TW), .NEAR_Z(NZ)
  ) dut (
    .clk(clk), .rst(rst), .cam_wr(cam_wr),
    .cam_c(cam_c), .cam_u(cam_u), .cam_v(cam_v), .cam_n(cam_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_tag(out_tag), .out_clip(out_clip)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint x, y, z;
    logic [TW-1:0] tag;
    bit clip;
    int acc;
    bit lat;
  } exp_t;

  exp_t sbq[$];
  longint mc[3], mu[3], mv[3], mn[3];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit lat_mode = 1'b0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // floor(a / 2^FB), rounding toward minus infinity
  function automatic longint fdiv(input longint a);
    longint s = longint'(1) << FB;
    longint q = a / s;
    if (q * s > a) q = q - 1;
    return q;
  endfunction

  function automatic longint wrap(input longint a);
    return (a <<< (64 - DW)) >>> (64 - DW);
  endfunction

  function automatic longint proj(input longint p0, p1, p2,
                                  input longint b0, b1, b2);
    return wrap(fdiv((p0 - mc[0]) * b0) + fdiv((p1 - mc[1]) * b1)
              + fdiv((p2 - mc[2]) * b2));
  endfunction

  function automatic exp_t model(input longint p0, p1, p2,
                                 input logic [TW-1:0] tg);
    exp_t e;
    e.x = proj(p0, p1, p2, mu[0], mu[1], mu[2]);
    e.y = proj(p0, p1, p2, mv[0], mv[1], mv[2]);
    e.z = proj(p0, p1, p2, mn[0], mn[1], mn[2]);
    e.tag = tg;
`ifdef CAM_XFORM_NEAR_CLIP_EN
    e.clip = (e.z < NZ);
`else
    e.clip = 1'b0;
`endif
    e.acc = cyc;
    e.lat = lat_mode;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0;
      mu[i] = (i == 0) ? ONEV : 0;
      mv[i] = (i == 1) ? ONEV : 0;
      mn[i] = (i == 2) ? ONEV : 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stale_out: got tag %0d, expected no output",
                   out_tag);
        end else begin
          chk("out_x", longint'(out_x), sbq[0].x);
          chk("out_y", longint'(out_y), sbq[0].y);
          chk("out_z", longint'(out_z), sbq[0].z);
          chk("out_tag", longint'(out_tag), longint'(sbq[0].tag));
          chk("out_clip", longint'(out_clip), longint'(sbq[0].clip));
          if (out_ready) begin
            if (sbq[0].lat) chk("latency", cyc - sbq[0].acc, 4);
            void'(sbq.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back(model(longint'($signed(in_p[0])),
                            longint'($signed(in_p[1])),
                            longint'($signed(in_p[2])), in_tag));
      end
      if (cam_wr) begin
        for (int i = 0; i < 3; i++) begin
          mc[i] = longint'($signed(cam_c[i]));
          mu[i] = longint'($signed(cam_u[i]));
          mv[i] = longint'($signed(cam_v[i]));
          mn[i] = longint'($signed(cam_n[i]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input int px, py, pz, input int tg);
    in_p[0] = PW'(px);
    in_p[1] = PW'(py);
    in_p[2] = PW'(pz);
    in_tag = TW'(tg);
  endtask

  task automatic cam_drive(input int cx, cy, cz, input int ux, uy, uz,
                           input int vx, vy, vz, input int nx, ny, nz);
    cam_c[0] = CW'(cx); cam_c[1] = CW'(cy); cam_c[2] = CW'(cz);
    cam_u[0] = VW'(ux); cam_u[1] = VW'(uy); cam_u[2] = VW'(uz);
    cam_v[0] = VW'(vx); cam_v[1] = VW'(vy); cam_v[2] = VW'(vz);
    cam_n[0] = VW'(nx); cam_n[1] = VW'(ny); cam_n[2] = VW'(nz);
    cam_wr = 1'b1;
  endtask

  task automatic send(input int px, py, pz, input int tg);
    bit acc = 1'b0;
    set_p(px, py, pz, tg);
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = in_ready;
      step();
      cam_wr = 1'b0;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (sbq.size() == 0) break;
      step();
    end
    repeat (3) step();
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_clip", out_clip, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("ready_after_rst", in_ready, 1);
    step();

    lat_mode = 1'b1;
    send(100, -200, 300, 8'h5A);
    drain();

    cam_drive(0, 0, 500, ONEV, 0, 0, 0, ONEV, 0, 0, 0, ONEV);
    send(0, 0, 100, 1);
    send(0, 0, 100, 2);
    drain();

    cam_drive(0, 0, 0, 8192, 0, 0, 0, ONEV, 0, 0, 0, ONEV);
    step();
    cam_wr = 1'b0;
    send(-1, 0, 0, 3);
    send(1, 0, 0, 4);
    drain();

    lat_mode = 1'b0;
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom % 4) != 0;
      set_p(int'($urandom), int'($urandom), int'($urandom),
            int'($urandom));
      out_ready = ($urandom % 3) != 0;
      if ($urandom % 20 == 0) begin
        cam_drive(int'($urandom), int'($urandom), int'($urandom),
                  int'($urandom), int'($urandom), int'($urandom),
                  int'($urandom), int'($urandom), int'($urandom),
                  int'($urandom), int'($urandom), int'($urandom));
      end else begin
        cam_wr = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    cam_wr = 1'b0;
    drain();

    cam_drive(0, 0, 0, ONEV, 0, 0, 0, ONEV, 0, 0, 0, ONEV);
    step();
    cam_wr = 1'b0;
    begin
      int idx = 0;
      int stall_acc = 0;
      bit acc;
      out_ready = 1'b0;
      set_p(0, 0, 7, 8'h30);
      in_valid = 1'b1;
      for (int k = 0; k < 80 && idx < 10; k++) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        if (k == 5) begin
          chk("full_in_ready", in_ready, 0);
          chk("stall_accepts", stall_acc, 4);
        end
        step();
        if (acc) begin
          if (k < 6) stall_acc++;
          idx++;
          if (idx < 10) set_p(idx * 10, -idx, 7 + idx, 8'h30 + idx);
          else in_valid = 1'b0;
        end
        if (k == 5) out_ready = 1'b1;
      end
      chk("stream_sent", idx, 10);
      in_valid = 1'b0;
    end
    drain();

    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      set_p(j + 1, 2 * j, -j, 8'hA0 + j);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    sbq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) step();
    lat_mode = 1'b1;
    send(7, 8, 9, 8'hEE);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
